icache_refill_ctrl: RTL and testbench

//  Miss/refill sequencer for the fetch stage. Watches the instruction-cache hit flag for the current PC.
//  On a miss it stalls the PC, fetches the 128-bit line from instruction memory over a req/ready handshake,

---
 rtl/icache_refill_ctrl_pkg.sv | 16 +
 rtl/icache_refill_ctrl_sat_counter.sv | 37 +++
 rtl/icache_refill_ctrl.sv | 116 +++++++++++
 tb/tb_icache_refill_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared line geometry and refill FSM state encoding for the fetch-stage
// instruction cache, its refill controller and the instruction memory.
package icache_refill_ctrl_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 128;
  localparam int DEF_OFFS_W = 4;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } refill_state_e;

endpackage

// File: rtl/icache_refill_ctrl_sat_counter.sv
// Unsigned up-counter that holds at all-ones instead of wrapping.
module icache_refill_ctrl_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_q, value_d;

  // NOTE: give every always_comb output a default first so no path leaves it
  // unassigned; an unassigned path infers a latch.
  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (inc && (value_q != {CNT_W{1'b1}})) begin
      value_d = value_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge value of the others, whatever the statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Miss/refill sequencer: stalls fetch on an I-cache miss, reads the line
// from memory, writes it into the cache, then lets the same PC look up again.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int OFFS_W = DEF_OFFS_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              cache_hit,
  input  logic              redirect,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_line,
  output logic              fill_en,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_line,
  output logic [CNT_W-1:0]  miss_count
);

  refill_state_e     state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              fill_en_q, fill_en_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [LINE_W-1:0] fill_line_q, fill_line_d;
  logic              miss_start;

  // A branch redirect only changes the PC, which is re-looked-up after the
  // stall releases, and the byte offset never reaches memory.
  logic unused_inputs;
  assign unused_inputs = ^{redirect, fetch_addr[OFFS_W-1:0]};

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    fill_en_d   = 1'b0;
    fill_addr_d = fill_addr_q;
    fill_line_d = fill_line_q;
    miss_start  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fetch_valid && !cache_hit) begin
          miss_start = 1'b1;
          mem_addr_d = {fetch_addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
          mem_req_d  = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          fill_line_d = mem_line;
          fill_addr_d = mem_addr_q;
          fill_en_d   = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = FILL;
        end
      end
      FILL: begin
        state_d = IDLE;
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // NOTE: the line buffer is reset too, so fill_line reads zero after reset
  // instead of whatever the flops powered up with.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      fill_en_q   <= 1'b0;
      fill_addr_q <= '0;
      fill_line_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      fill_en_q   <= fill_en_d;
      fill_addr_q <= fill_addr_d;
      fill_line_q <= fill_line_d;
    end
  end

  // Combinational so the PC is held in the very cycle the miss is seen.
  assign stall = (state_q != IDLE) || ((state_q == IDLE) && fetch_valid && !cache_hit);

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign fill_en   = fill_en_q;
  assign fill_addr = fill_addr_q;
  assign fill_line = fill_line_q;

  icache_refill_ctrl_sat_counter #(
    .CNT_W(CNT_W)
  ) u_miss_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (miss_start),
    .clear(1'b0),
    .value(miss_count)
  );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: directed scenarios plus random
// refills checked against a transaction-level latency/counter model.
module tb_icache_refill_ctrl;

  localparam int CNT_MAX = 15;

  logic         clk;
  logic         reset;
  logic         fetch_valid;
  logic [31:0]  fetch_addr;
  logic         cache_hit;
  logic         redirect;
  logic         stall;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready;
  logic [127:0] mem_line;
  logic         fill_en;
  logic [31:0]  fill_addr;
  logic [127:0] fill_line;
  logic [3:0]   miss_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_count    = 0;

  icache_refill_ctrl #(
    .ADDR_W(32), .LINE_W(128), .OFFS_W(4), .CNT_W(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_valid(fetch_valid),
    .fetch_addr (fetch_addr),
    .cache_hit  (cache_hit),
    .redirect   (redirect),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_line   (mem_line),
    .fill_en    (fill_en),
    .fill_addr  (fill_addr),
    .fill_line  (fill_line),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One complete refill: miss in cycle 0, ready in cycle d (or held from
  // cycle 1), fill in cycle d+1, stall high for d+2 cycles. With chain set
  // the caller's next miss uses the first IDLE cycle after the fill.
  task automatic do_miss(input logic [31:0] addr, input int d, input bit held,
                         input logic [127:0] line, input bit wander, input bit chain);
    int          stall_cnt;
    int          fill_cnt;
    logic [31:0] exp_addr;
    stall_cnt = 0;
    fill_cnt  = 0;
    exp_addr  = addr & 32'hFFFF_FFF0;
    exp_count = (exp_count < CNT_MAX) ? exp_count + 1 : CNT_MAX;
    for (int c = 0; c <= d + 1; c++) begin
      @(negedge clk);
      if (c == 0) begin
        fetch_valid = 1'b1;
        fetch_addr  = addr;
        cache_hit   = 1'b0;
        redirect    = 1'b0;
      end else begin
        fetch_valid = 1'($urandom);
        cache_hit   = 1'($urandom);
        fetch_addr  = wander ? 32'h0000_0100 : $urandom;
        redirect    = wander ? (c == 2) : 1'($urandom);
      end
      mem_ready = held ? 1'b1 : (c == d);
      mem_line  = (c == d) ? line : rand_line();
      #1;
      if (stall) stall_cnt++;
      if (fill_en) fill_cnt++;
      if (c == 0) begin
        tests_run++;
        if (mem_req !== 1'b0) begin
          tests_failed++;
          $display("FAIL miss_cycle_req: mem_req=%0b expected 0", mem_req);
        end
      end else if (c <= d) begin
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== exp_addr || fill_en !== 1'b0) begin
          tests_failed++;
          $display("FAIL req_phase c=%0d: mem_req=%0b mem_addr=%h fill_en=%0b expected 1/%h/0",
                   c, mem_req, mem_addr, fill_en, exp_addr);
        end
      end else begin
        tests_run++;
        if (fill_en !== 1'b1 || fill_addr !== exp_addr || fill_line !== line || mem_req !== 1'b0) begin
          tests_failed++;
          $display("FAIL fill_phase: fill_en=%0b fill_addr=%h fill_line=%h mem_req=%0b expected 1/%h/%h/0",
                   fill_en, fill_addr, fill_line, mem_req, exp_addr, line);
        end
        tests_run++;
        if (miss_count !== 4'(exp_count)) begin
          tests_failed++;
          $display("FAIL miss_count: got %0d expected %0d", miss_count, exp_count);
        end
      end
    end
    tests_run++;
    if (stall_cnt != d + 2 || fill_cnt != 1) begin
      tests_failed++;
      $display("FAIL refill_shape: stall cycles=%0d fill pulses=%0d expected %0d/1",
               stall_cnt, fill_cnt, d + 2);
    end
    if (!chain) begin
      @(negedge clk);
      fetch_valid = 1'b1;
      fetch_addr  = wander ? 32'h0000_0100 : addr;
      cache_hit   = 1'b1;
      redirect    = 1'b0;
      mem_ready   = held;
      #1;
      tests_run++;
      if (stall !== 1'b0 || mem_req !== 1'b0 || fill_en !== 1'b0) begin
        tests_failed++;
        $display("FAIL release: stall=%0b mem_req=%0b fill_en=%0b expected 0/0/0",
                 stall, mem_req, fill_en);
      end
    end
  endtask

  // Cycles with no miss: stray mem_ready and redirect must have no effect.
  task automatic idle_hits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fetch_valid = 1'($urandom);
      cache_hit   = fetch_valid ? 1'b1 : 1'($urandom);
      fetch_addr  = $urandom;
      redirect    = 1'($urandom);
      mem_ready   = 1'($urandom);
      mem_line    = rand_line();
      #1;
      tests_run++;
      if (stall !== 1'b0 || mem_req !== 1'b0 || fill_en !== 1'b0 || miss_count !== 4'(exp_count)) begin
        tests_failed++;
        $display("FAIL idle_hit: stall=%0b mem_req=%0b fill_en=%0b miss_count=%0d expected 0/0/0/%0d",
                 stall, mem_req, fill_en, miss_count, exp_count);
      end
    end
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    fetch_valid = 1'b1;
    fetch_addr  = 32'h0000_0024;
    cache_hit   = 1'b0;
    redirect    = 1'b0;
    mem_ready   = 1'b1;
    mem_line    = rand_line();
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (mem_req !== 1'b0 || fill_en !== 1'b0 || miss_count !== 4'd0 ||
        mem_addr !== 32'd0 || fill_addr !== 32'd0 || fill_line !== 128'd0) begin
      tests_failed++;
      $display("FAIL reset_values: mem_req=%0b fill_en=%0b miss_count=%0d mem_addr=%h fill_addr=%h fill_line=%h expected all 0",
               mem_req, fill_en, miss_count, mem_addr, fill_addr, fill_line);
    end
    fetch_valid = 1'b0;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_stall: stall=%0b expected 0", stall);
    end
    fetch_valid = 1'b1;
    mem_ready   = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    exp_count = 0;
    do_miss(32'h0000_0024, 2, 1'b0, rand_line(), 1'b0, 1'b0);
  endtask

  task automatic test_basic_miss();
    do_miss(32'h0000_0014, 3, 1'b0, 128'hAAAA_AAAA_AAAA_AAAA_BBBB_BBBB_BBBB_BBBB,
            1'b0, 1'b0);
  endtask

  task automatic test_fast_ready();
    do_miss(32'h0000_2238, 1, 1'b1, rand_line(), 1'b0, 1'b0);
    idle_hits(2);
  endtask

  task automatic test_redirect_back_to_back();
    do_miss(32'h0000_0014, 3, 1'b0, rand_line(), 1'b1, 1'b1);
    do_miss(32'h0000_0100, 2, 1'b0, rand_line(), 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_addr  = 32'h0000_0044;
    cache_hit   = 1'b0;
    mem_ready   = 1'b0;
    repeat (2) @(negedge clk);
    fetch_valid = 1'b0;
    #2 reset = 1'b0;
    exp_count = 0;
    #1;
    tests_run++;
    if (mem_req !== 1'b0 || fill_en !== 1'b0 || miss_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_req: mem_req=%0b fill_en=%0b miss_count=%0d expected 0/0/0",
               mem_req, fill_en, miss_count);
    end
    mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    idle_hits(3);
    do_miss(32'h0000_0048, 2, 1'b0, rand_line(), 1'b0, 1'b0);
  endtask

  task automatic test_random_refills();
    for (int i = 0; i < 12; i++) begin
      int d;
      d = $urandom_range(1, 4);
      do_miss($urandom, d, (d == 1) && 1'($urandom), rand_line(), 1'b0, 1'($urandom));
      if (i % 3 == 2) idle_hits($urandom_range(1, 3));
    end
    idle_hits(1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 17; i++) begin
      do_miss($urandom, $urandom_range(1, 3), 1'b0, rand_line(), 1'b0, 1'b0);
      idle_hits(1);
    end
    tests_run++;
    if (miss_count !== 4'd15) begin
      tests_failed++;
      $display("FAIL saturation: miss_count=%0d expected 15", miss_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_miss();
    test_fast_ready();
    test_redirect_back_to_back();
    test_reset_mid_req();
    test_random_refills();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
